// File: rtl/wb_commit_buf.sv
// Write-back commit buffer.
// Retiring MEM-stage instructions are queued in a small circular FIFO and
// drained into the register-file write port whenever it is free. Buffered
// GPR results are visible to a bypass lookup so younger instructions can
// forward from entries that have not yet reached the register file.
module wb_commit_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int SB_W   = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_we,
  input  logic [4:0]        in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [SB_W-1:0]   in_sb,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [SB_W-1:0]   rf_sb,
  input  logic [4:0]        q_addr,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Entry storage; only occupied slots are ever observed on outputs.
  logic [31:0]       pc_mem    [DEPTH];
  logic              we_mem    [DEPTH];
  logic [4:0]        waddr_mem [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];
  logic [SB_W-1:0]   sb_mem    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             occupied;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] bp_idx;
  logic             bp_hit;
  logic [DATA_W-1:0] bp_data;

  assign occupied = (count != '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = occupied & rf_ready & ~flush;

  // Head entry presented combinationally; zeroed when nothing is buffered.
  assign rf_we    = pop & we_mem[head];
  assign rf_waddr = occupied ? waddr_mem[head] : 5'd0;
  assign rf_wdata = occupied ? wdata_mem[head] : '0;
  assign rf_sb    = occupied ? sb_mem[head]    : '0;

  assign debug_wb_pc      = pop ? pc_mem[head] : 32'd0;
  assign debug_wb_rf_wen  = {4{rf_we}};
  assign debug_wb_rf_wnum = rf_waddr;

  generate
    if (DATA_W >= 32) begin : g_dbg_trunc
      assign debug_wb_rf_wdata = rf_wdata[31:0];
    end else begin : g_dbg_ext
      assign debug_wb_rf_wdata = {{(32 - DATA_W){1'b0}}, rf_wdata};
    end
  endgenerate

  // Capture the presented instruction into the tail slot; a write to GPR 0 is stored as no-write.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= in_pc;
      we_mem[tail]    <= in_we & (in_waddr != 5'd0);
      waddr_mem[tail] <= in_waddr;
      wdata_mem[tail] <= in_wdata;
      sb_mem[tail]    <= in_sb;
    end
  end

  // Pointer and occupancy bookkeeping; flush and reset both empty the buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bypass scan oldest-to-youngest so the last match (youngest) wins; head is included even while popping.
  always_comb begin
    bp_hit  = 1'b0;
    bp_data = '0;
    bp_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bp_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && we_mem[bp_idx] && (waddr_mem[bp_idx] == q_addr) &&
          (q_addr != 5'd0)) begin
        bp_hit  = 1'b1;
        bp_data = wdata_mem[bp_idx];
      end
    end
  end

  assign q_hit  = bp_hit;
  assign q_data = bp_data;

endmodule

// File: tb/tb_wb_commit_buf.sv
// Testbench for wb_commit_buf: directed scenarios plus a randomized run
// checked against a queue-based model of the commit buffer.
module tb_wb_commit_buf;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int SB_W   = 14;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic              in_we;
  logic [4:0]        in_waddr;
  logic [DATA_W-1:0] in_wdata;
  logic [SB_W-1:0]   in_sb;
  logic              rf_ready;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [SB_W-1:0]   rf_sb;
  logic [4:0]        q_addr;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;
  logic [2:0]        count;
  logic [31:0]       debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [31:0]       debug_wb_rf_wdata;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0]       pc;
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic [SB_W-1:0]   sb;
  } ent_t;

  ent_t mq[$];

  always #5 clk = ~clk;

  wb_commit_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SB_W(SB_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_we(in_we),
    .in_waddr(in_waddr), .in_wdata(in_wdata), .in_sb(in_sb),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_sb(rf_sb), .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .count(count),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // ---------------- reference model ----------------
  function automatic logic m_pop();
    return resetn && !flush && (mq.size() > 0) && rf_ready;
  endfunction

  function automatic logic m_rf_we();
    return m_pop() && mq[0].we;
  endfunction

  function automatic logic [4:0] m_waddr();
    return (resetn && mq.size() > 0) ? mq[0].waddr : 5'd0;
  endfunction

  function automatic logic [DATA_W-1:0] m_wdata();
    return (resetn && mq.size() > 0) ? mq[0].wdata : '0;
  endfunction

  function automatic logic [SB_W-1:0] m_sb();
    return (resetn && mq.size() > 0) ? mq[0].sb : '0;
  endfunction

  function automatic logic [31:0] m_dbg_pc();
    return m_pop() ? mq[0].pc : 32'd0;
  endfunction

  function automatic logic m_qhit();
    if (q_addr == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].we && mq[i].waddr == q_addr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] m_qdata();
    if (q_addr == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].we && mq[i].waddr == q_addr) return mq[i].wdata;
    return '0;
  endfunction

  // Advance one clock and apply the buffer rules to the model.
  task automatic tick();
    ent_t e;
    logic do_pop, do_push;
    @(posedge clk);
    if (!resetn || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && rf_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc = in_pc; e.we = in_we && (in_waddr != 5'd0); e.waddr = in_waddr;
        e.wdata = in_wdata; e.sb = in_sb;
        mq.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [13:0] sb, input logic rr, input logic fl);
    @(negedge clk);
    in_valid = v; in_pc = pc; in_we = we; in_waddr = wa; in_wdata = wd;
    in_sb = sb; rf_ready = rr; flush = fl;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; flush = 0; in_valid = 0; in_pc = 0; in_we = 0; in_waddr = 0;
    in_wdata = 0; in_sb = 0; rf_ready = 1; q_addr = 5'd3;
    mq.delete();
    #2;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    vectors++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || rf_sb !== 14'd0) begin miscompares++; $display("FAIL reset_rf got we=%0b wa=%0h wd=%0h sb=%0h want all 0", rf_we, rf_waddr, rf_wdata, rf_sb); end
    vectors++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0) begin miscompares++; $display("FAIL reset_debug got pc=%0h wen=%0h want 0", debug_wb_pc, debug_wb_rf_wen); end
    vectors++; if (q_hit !== 1'b0 || q_data !== 32'd0) begin miscompares++; $display("FAIL reset_bypass got hit=%0b data=%0h want 0", q_hit, q_data); end
    repeat (2) tick();
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 32'hBFC00000, 1, 5'd3, 32'h1234, 14'h5, 1, 0);
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL basic_empty_we got %0b want 0", rf_we); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL basic_rf_we got %0b want 1", rf_we); end
    vectors++; if (rf_waddr !== 5'd3) begin miscompares++; $display("FAIL basic_rf_waddr got %0d want 3", rf_waddr); end
    vectors++; if (rf_wdata !== 32'h1234 || debug_wb_rf_wdata !== 32'h1234) begin miscompares++; $display("FAIL basic_rf_wdata got %0h/%0h want 1234", rf_wdata, debug_wb_rf_wdata); end
    vectors++; if (rf_sb !== 14'h5) begin miscompares++; $display("FAIL basic_rf_sb got %0h want 5", rf_sb); end
    vectors++; if (debug_wb_rf_wen !== 4'hF) begin miscompares++; $display("FAIL basic_wen got %0h want f", debug_wb_rf_wen); end
    vectors++; if (debug_wb_pc !== 32'hBFC00000) begin miscompares++; $display("FAIL basic_dbg_pc got %0h want bfc00000", debug_wb_pc); end
    vectors++; if (debug_wb_rf_wnum !== 5'd3) begin miscompares++; $display("FAIL basic_wnum got %0d want 3", debug_wb_rf_wnum); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL basic_count_after got %0d want 0", count); end
    vectors++; if (rf_we !== 1'b0 || debug_wb_pc !== 32'd0) begin miscompares++; $display("FAIL basic_idle got we=%0b pc=%0h want 0", rf_we, debug_wb_pc); end
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h1000 + 4 * i, 1, 5'(i + 1), 32'h100 + i, 0, 0, 0);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_fill%0d got %0b want 1", i, in_ready); end
      tick();
    end
    drive(1, 32'h1010, 1, 5'd5, 32'h104, 0, 0, 0);
    vectors++; if (in_ready !== 1'b0 || count !== 3'd4) begin miscompares++; $display("FAIL bp_full got ready=%0b count=%0d want 0/4", in_ready, count); end
    tick();
    drive(1, 32'h1010, 1, 5'd5, 32'h104, 0, 1, 0);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_pop_ready got %0b want 0", in_ready); end
    vectors++; if (rf_we !== 1'b1 || rf_wdata !== 32'h100) begin miscompares++; $display("FAIL bp_drain0 got we=%0b wd=%0h want 1/100", rf_we, rf_wdata); end
    tick();
    drive(1, 32'h1010, 1, 5'd5, 32'h104, 0, 1, 0);
    vectors++; if (in_ready !== 1'b1 || count !== 3'd3) begin miscompares++; $display("FAIL bp_accept5 got ready=%0b count=%0d want 1/3", in_ready, count); end
    vectors++; if (rf_wdata !== 32'h101 || debug_wb_pc !== 32'h1004) begin miscompares++; $display("FAIL bp_drain1 got wd=%0h pc=%0h want 101/1004", rf_wdata, debug_wb_pc); end
    tick();
    for (int i = 2; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      vectors++; if (rf_we !== 1'b1 || rf_wdata !== 32'h100 + i || rf_waddr !== 5'(i + 1)) begin miscompares++; $display("FAIL bp_drain%0d got we=%0b wa=%0d wd=%0h want 1/%0d/%0h", i, rf_we, rf_waddr, rf_wdata, i + 1, 32'h100 + i); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL bp_empty got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    drive(1, 32'h2000, 1, 5'd7, 32'hA, 0, 0, 0); tick();
    drive(1, 32'h2004, 1, 5'd7, 32'hB, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    q_addr = 5'd7; #1;
    vectors++; if (q_hit !== 1'b1 || q_data !== 32'hB) begin miscompares++; $display("FAIL bypass_youngest got hit=%0b data=%0h want 1/b", q_hit, q_data); end
    q_addr = 5'd0; #1;
    vectors++; if (q_hit !== 1'b0 || q_data !== 32'd0) begin miscompares++; $display("FAIL bypass_zero got hit=%0b data=%0h want 0/0", q_hit, q_data); end
    q_addr = 5'd6; #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL bypass_miss got hit=%0b want 0", q_hit); end
    drive(1, 32'h2008, 1, 5'd6, 32'hC, 0, 1, 0);
    q_addr = 5'd6; #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL bypass_same_cycle_push got hit=%0b want 0", q_hit); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    q_addr = 5'd7; #1;
    vectors++; if (q_hit !== 1'b1 || q_data !== 32'hB) begin miscompares++; $display("FAIL bypass_head_pop got hit=%0b data=%0h want 1/b", q_hit, q_data); end
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 1, 0); tick(); end
  endtask

  task automatic test_zero_waddr();
    drive(1, 32'h80001000, 1, 5'd0, 32'hDEAD, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'd0) begin miscompares++; $display("FAIL zero_waddr_we got we=%0b wen=%0h want 0", rf_we, debug_wb_rf_wen); end
    vectors++; if (debug_wb_pc !== 32'h80001000) begin miscompares++; $display("FAIL zero_waddr_pc got %0h want 80001000", debug_wb_pc); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL zero_waddr_retired got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3000 + 4 * i, 1, 5'(9 + i), 32'h30 + i, 0, 0, 0); tick();
    end
    drive(1, 32'h300C, 1, 5'd12, 32'h33, 0, 1, 1);
    q_addr = 5'd9; #1;
    vectors++; if (rf_we !== 1'b0 || debug_wb_pc !== 32'd0) begin miscompares++; $display("FAIL flush_cycle got we=%0b pc=%0h want 0/0", rf_we, debug_wb_pc); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++; if (count !== 3'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_after got count=%0d ready=%0b want 0/1", count, in_ready); end
    q_addr = 5'd12; #1;
    vectors++; if (q_hit !== 1'b0 || rf_we !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got hit=%0b we=%0b want 0/0", q_hit, rf_we); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h4000, 1, 5'd4, 32'h40, 14'h3, 0, 0); tick();
    drive(1, 32'h4004, 1, 5'd5, 32'h41, 14'h3, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    q_addr = 5'd4; #1;
    vectors++; if (count !== 3'd2 || q_hit !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got count=%0d hit=%0b want 2/1", count, q_hit); end
    resetn = 1'b0; rf_ready = 1'b1; #1;
    vectors++; if (count !== 3'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_count got count=%0d ready=%0b want 0/1", count, in_ready); end
    vectors++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || rf_sb !== 14'd0) begin miscompares++; $display("FAIL rstmid_rf got we=%0b wa=%0h wd=%0h sb=%0h want 0", rf_we, rf_waddr, rf_wdata, rf_sb); end
    vectors++; if (q_hit !== 1'b0 || debug_wb_pc !== 32'd0) begin miscompares++; $display("FAIL rstmid_misc got hit=%0b pc=%0h want 0/0", q_hit, debug_wb_pc); end
    tick();
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      vectors++; if (rf_we !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL rstmid_post%0d got we=%0b count=%0d want 0/0", i, rf_we, count); end
      tick();
    end
  endtask

  task automatic test_random();
    logic rr;
    for (int n = 0; n < 400; n++) begin
      rr = (n < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      drive($urandom_range(3) != 0, $urandom, $urandom_range(3) != 0, 5'($urandom_range(7)),
            $urandom, 14'($urandom), rr, $urandom_range(24) == 0);
      q_addr = 5'($urandom_range(7)); #1;
      vectors++; if (count !== 3'(mq.size())) begin miscompares++; $display("FAIL rnd%0d_count got %0d want %0d", n, count, mq.size()); end
      vectors++; if (in_ready !== (mq.size() != DEPTH)) begin miscompares++; $display("FAIL rnd%0d_in_ready got %0b want %0b", n, in_ready, mq.size() != DEPTH); end
      vectors++; if (rf_we !== m_rf_we() || debug_wb_rf_wen !== {4{m_rf_we()}}) begin miscompares++; $display("FAIL rnd%0d_rf_we got %0b/%0h want %0b", n, rf_we, debug_wb_rf_wen, m_rf_we()); end
      vectors++; if (rf_waddr !== m_waddr() || debug_wb_rf_wnum !== m_waddr()) begin miscompares++; $display("FAIL rnd%0d_waddr got %0d/%0d want %0d", n, rf_waddr, debug_wb_rf_wnum, m_waddr()); end
      vectors++; if (rf_wdata !== m_wdata() || debug_wb_rf_wdata !== m_wdata()) begin miscompares++; $display("FAIL rnd%0d_wdata got %0h/%0h want %0h", n, rf_wdata, debug_wb_rf_wdata, m_wdata()); end
      vectors++; if (rf_sb !== m_sb()) begin miscompares++; $display("FAIL rnd%0d_sb got %0h want %0h", n, rf_sb, m_sb()); end
      vectors++; if (debug_wb_pc !== m_dbg_pc()) begin miscompares++; $display("FAIL rnd%0d_dbg_pc got %0h want %0h", n, debug_wb_pc, m_dbg_pc()); end
      vectors++; if (q_hit !== m_qhit() || q_data !== m_qdata()) begin miscompares++; $display("FAIL rnd%0d_bypass got %0b/%0h want %0b/%0h", n, q_hit, q_data, m_qhit(), m_qdata()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bypass();
    test_zero_waddr();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_commit_buf.md
WB_COMMIT_BUF -- requirements
Module: wb_commit_buf

Interface
REQ-001 Parameter DATA_W, default 32, result data width.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, 2..16.
REQ-003 Parameter SB_W, default 14, HI/LO sideband width carried alongside each result.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  MEM stage presents a retiring instruction.
REQ-008 in_ready  output  1  buffer accepts the presented instruction this cycle.
REQ-009 in_pc  input  32  instruction PC.
REQ-010 in_we  input  1  GPR write enable.
REQ-011 in_waddr  input  5  GPR destination.
REQ-012 in_wdata  input  DATA_W  GPR write data.
REQ-013 in_sb  input  SB_W  HI/LO sideband.
REQ-014 rf_ready  input  1  the register-file write port is free this cycle.
REQ-015 rf_we, rf_waddr, rf_wdata, rf_sb  output  1/5/DATA_W/SB_W  register-file write port.
REQ-016 q_addr  input  5; q_hit  output  1; q_data  output  DATA_W; bypass lookup.
REQ-017 count  output  $clog2(DEPTH+1)  occupied entries.
REQ-018 debug_wb_pc  output  32; debug_wb_rf_wen  output  4; debug_wb_rf_wnum  output  5; debug_wb_rf_wdata  output  32.

Function
REQ-019 The block SHALL be a circular FIFO of DEPTH entries {pc, we, waddr, wdata, sb}, with head/tail pointers and a count register.
REQ-020 in_ready SHALL equal (count != DEPTH) and SHALL be driven from registered state only.
REQ-021 A push SHALL occur on (in_valid & in_ready & !flush); on push, stored we SHALL equal in_we & (in_waddr != 0).
REQ-022 A pop SHALL occur on (count != 0) & rf_ready & !flush, retiring the head entry, whether or not its we is set.
REQ-023 rf_we SHALL equal pop & head.we; rf_waddr, rf_wdata and rf_sb SHALL present the head fields combinationally, and SHALL be 0 when count = 0.
REQ-024 debug_wb_pc SHALL equal head.pc on pop and 0 otherwise; debug_wb_rf_wen = {4{rf_we}}; wnum/wdata mirror rf_waddr/rf_wdata, with wdata zero-extended or truncated to 32 bits.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; at count = DEPTH, push is refused even when a pop occurs in the same cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 Latency: an instruction pushed into an empty buffer at edge N SHALL be presented on rf_* in cycle N+1.
REQ-028 flush SHALL force rf_we = 0 and debug_wb_pc = 0 in that cycle; at the next edge count, head and tail SHALL be 0, and any same-cycle push is dropped.
REQ-029 q_hit SHALL be 1 when q_addr != 0 and some occupied entry has we = 1 with waddr = q_addr.
REQ-030 q_data SHALL be the wdata of the youngest matching entry, and 0 when q_hit = 0.
REQ-031 Bypass SHALL NOT consider the same-cycle in_* push, and SHALL include the head entry even in a cycle in which it pops.

Reset
REQ-032 On resetn low, asynchronously: count, head and tail SHALL be 0; all rf_*, debug_* and q_* outputs SHALL be 0; in_ready SHALL be 1.
REQ-033 Entry storage need not be reset; outputs SHALL never expose storage of unoccupied entries.
REQ-034 Reset asserted mid-operation SHALL discard all entries, and no rf_we SHALL follow until a new push.

Verification
REQ-035 Push pc=0xBFC00000, we=1, waddr=3, wdata=0x1234 with rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, debug_wb_rf_wen=4'hF, debug_wb_pc=0xBFC00000; count returns to 0.
REQ-036 rf_ready=0 with 5 pushes at DEPTH=4 -> in_ready=0 after 4 pushes and the 5th is held; raising rf_ready drains 4 entries in order over 4 cycles, and the 5th is accepted the cycle after the first pop.
REQ-037 Buffer holds waddr=7/0xA then waddr=7/0xB -> q_addr=7 gives q_hit=1, q_data=0xB; q_addr=0 gives q_hit=0.
REQ-038 Push with waddr=0, we=1 -> on pop rf_we=0, debug_wb_rf_wen=0, debug_wb_pc valid.
REQ-039 Three entries buffered, flush asserted with in_valid=1 -> no rf_we that cycle; next cycle count=0, in_ready=1, q_hit=0.
REQ-040 resetn pulsed low mid-stream at count=2 -> outputs 0 immediately and no write after release.
